mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM arbiter for a shared single-port memory
//
// Grants one outstanding access at a time to either the instruction-fetch
// stage or the load/store stage; MEM always wins a contested arbitration.
// The cycle after portReady carries the Done pulse and re-arbitrates, with the
// just-served requester masked so its still-high request is not re-granted.
//
// Optional feature: define ARB_TIMEOUT_EN to abort accesses that see no
// portReady for TIMEOUT_CYCLES busy cycles (Done with zero data, sticky arbError).
//
// Ports:
//   clk, resetManual            clock, asynchronous active-low reset
//   ifReq, ifAddr               fetch request / address
//   ifRdata, ifDone             fetch data, one-cycle completion pulse
//   memRead, memWrite           load / store request (both high = store)
//   memAddr, memWdata           load/store address, store data
//   memRdata, memDone           load data (0 for stores), completion pulse
//   portReq, portWe             memory request / write enable
//   portAddr, portWdata         registered memory address / write data
//   portRdata, portReady        memory read data / access completion
//   PCWrite, IF_ID_Write        low freezes PC and IF/ID register
//   memStall                    high freezes ID/EX, EX/MEM, MEM/WB
//   arbError                    sticky timeout flag
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetManual,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic [31:0] ifRdata,
    output logic        ifDone,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] memAddr,
    input  logic [31:0] memWdata,
    output logic [31:0] memRdata,
    output logic        memDone,
    output logic        portReq,
    output logic        portWe,
    output logic [31:0] portAddr,
    output logic [31:0] portWdata,
    input  logic [31:0] portRdata,
    input  logic        portReady,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        memStall,
    output logic        arbError
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

    state_t      state_q, state_d;
    logic        port_req_q, port_req_d;
    logic        port_we_q, port_we_d;
    logic [31:0] port_addr_q, port_addr_d;
    logic [31:0] port_wdata_q, port_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic        tmo_hit;
    logic        mem_pending;
    logic        if_pending;
    logic        finish;
    logic [31:0] finish_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          arb_error_q, arb_error_d;

    // Counter is held at zero while idle, so every BUSY entry starts from zero.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        arb_error_d = arb_error_q;
        tmo_hit     = 1'b0;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (!portReady) begin
            if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit     = 1'b1;
                arb_error_d = 1'b1;
                tmo_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            tmo_cnt_q   <= '0;
            arb_error_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            arb_error_q <= arb_error_d;
        end
    end

    assign arbError = arb_error_q;
`else
    assign tmo_hit  = 1'b0;
    assign arbError = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        port_req_d   = port_req_q;
        port_we_d    = port_we_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;

        // A requester being acknowledged this cycle still holds its request.
        mem_pending = (memRead | memWrite) & ~mem_done_q;
        if_pending  = ifReq & ~if_done_q;

        finish      = portReady | tmo_hit;
        finish_data = portReady ? portRdata : 32'h0;

        case (state_q)
            IDLE: begin
                if (mem_pending) begin
                    state_d      = MEM_BUSY;
                    port_req_d   = 1'b1;
                    port_we_d    = memWrite;
                    port_addr_d  = memAddr;
                    port_wdata_d = memWdata;
                end else if (if_pending) begin
                    state_d      = IF_BUSY;
                    port_req_d   = 1'b1;
                    port_we_d    = 1'b0;
                    port_addr_d  = ifAddr;
                    port_wdata_d = 32'h0;
                end
            end
            IF_BUSY: begin
                if (finish) begin
                    state_d    = IDLE;
                    port_req_d = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = finish_data;
                end
            end
            MEM_BUSY: begin
                if (finish) begin
                    state_d     = IDLE;
                    port_req_d  = 1'b0;
                    mem_done_d  = 1'b1;
                    mem_rdata_d = port_we_q ? 32'h0 : finish_data;
                end
            end
            default: begin
                state_d    = IDLE;
                port_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetManual) begin
        if (!resetManual) begin
            state_q      <= IDLE;
            port_req_q   <= 1'b0;
            port_we_q    <= 1'b0;
            port_addr_q  <= 32'h0;
            port_wdata_q <= 32'h0;
            if_rdata_q   <= 32'h0;
            mem_rdata_q  <= 32'h0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_req_q   <= port_req_d;
            port_we_q    <= port_we_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
        end
    end

    assign portReq     = port_req_q;
    assign portWe      = port_we_q;
    assign portAddr    = port_addr_q;
    assign portWdata   = port_wdata_q;
    assign ifRdata     = if_rdata_q;
    assign memRdata    = mem_rdata_q;
    assign ifDone      = if_done_q;
    assign memDone     = mem_done_q;

    assign memStall    = (memRead | memWrite) & ~mem_done_q;
    assign PCWrite     = ~((ifReq & ~if_done_q) | memStall);
    assign IF_ID_Write = PCWrite;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        resetManual;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifDone;
    logic        memRead, memWrite;
    logic [31:0] memAddr, memWdata;
    logic [31:0] memRdata;
    logic        memDone;
    logic        portReq, portWe;
    logic [31:0] portAddr, portWdata;
    logic [31:0] portRdata;
    logic        portReady;
    logic        PCWrite, IF_ID_Write, memStall, arbError;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetManual(resetManual),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memDone(memDone),
        .portReq(portReq), .portWe(portWe), .portAddr(portAddr), .portWdata(portWdata),
        .portRdata(portRdata), .portReady(portReady),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .memStall(memStall), .arbError(arbError)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: who owns the port, who is being acknowledged.
    int          m_owner;   // 0 none, 1 IF, 2 MEM
    int          m_done;    // requester acknowledged in the current cycle
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we;
    int          m_cnt;
    logic        m_err;

    task automatic model_reset();
        m_owner = 0; m_done = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        m_we = 0; m_cnt = 0; m_err = 0;
    endtask

    // Called right after a rising edge, while inputs still hold pre-edge values.
    task automatic model_edge();
        int prev_done;
        if (!resetManual) begin
            model_reset();
            return;
        end
        prev_done = m_done;
        m_done    = 0;
        if (m_owner != 0) begin
            if (portReady) begin
                m_done  = m_owner;
                m_rdata = (m_owner == 2 && m_we) ? 32'h0 : portRdata;
                m_owner = 0;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                m_cnt++;
                if (m_cnt == TMO) begin
                    m_done  = m_owner;
                    m_rdata = 32'h0;
                    m_err   = 1'b1;
                    m_owner = 0;
                end
            end
`endif
        end else if ((memRead || memWrite) && prev_done != 2) begin
            m_owner = 2; m_addr = memAddr; m_wdata = memWdata; m_we = memWrite; m_cnt = 0;
        end else if (ifReq && prev_done != 1) begin
            m_owner = 1; m_addr = ifAddr; m_wdata = 0; m_we = 0; m_cnt = 0;
        end
    endtask

    logic obs_if_done, obs_mem_done;

    task automatic check_cycle();
        logic exp_stall, exp_pcw;
        check_eq("portReq", portReq, m_owner != 0);
        if (m_owner != 0) begin
            check_eq("portAddr", portAddr, m_addr);
            check_eq("portWe", portWe, m_we);
            check_eq("portWdata", portWdata, m_wdata);
        end
        check_eq("ifDone", ifDone, m_done == 1);
        check_eq("memDone", memDone, m_done == 2);
        if (m_done == 1) check_eq("ifRdata", ifRdata, m_rdata);
        if (m_done == 2) check_eq("memRdata", memRdata, m_rdata);
        exp_stall = (memRead || memWrite) && (m_done != 2);
        exp_pcw   = !((ifReq && m_done != 1) || exp_stall);
        check_eq("memStall", memStall, exp_stall);
        check_eq("PCWrite", PCWrite, exp_pcw);
        check_eq("IF_ID_Write", IF_ID_Write, exp_pcw);
        check_eq("arbError", arbError, m_err);
        obs_if_done  = ifDone;
        obs_mem_done = memDone;
    endtask

    logic rand_en, hold_ready, acc_active;
    int   delay;

    task automatic new_mem_req();
        case ($urandom_range(0, 2))
            0:       begin memRead = 1; memWrite = 0; end
            1:       begin memRead = 0; memWrite = 1; end
            default: begin memRead = 1; memWrite = 1; end
        endcase
        memAddr  = $urandom;
        memWdata = $urandom;
    endtask

    task automatic drive();
        if (rand_en) begin
            if (ifReq) begin
                if (obs_if_done) begin
                    ifReq  = ($urandom_range(0, 1) == 1);
                    ifAddr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ifReq  = 1;
                ifAddr = $urandom;
            end
            if (memRead || memWrite) begin
                if (obs_mem_done) begin
                    memRead = 0; memWrite = 0;
                    if ($urandom_range(0, 1) == 1) new_mem_req();
                end
            end else if ($urandom_range(0, 3) == 0) begin
                new_mem_req();
            end
        end
        if (!portReq) acc_active = 0;
        if (portReq && !acc_active) begin
            acc_active = 1;
            delay      = $urandom_range(0, 5);
        end
        if (acc_active) begin
            if (!hold_ready && delay == 0) begin
                portReady  = 1;
                acc_active = 0;
            end else begin
                portReady = 0;
                if (delay > 0) delay--;
            end
        end else begin
            portReady = ($urandom_range(0, 3) == 0);
        end
        portRdata = $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
        drive();
    endtask

    initial begin
        resetManual = 0; ifReq = 0; ifAddr = 0; memRead = 0; memWrite = 0;
        memAddr = 0; memWdata = 0; portRdata = 0; portReady = 0;
        rand_en = 1; hold_ready = 0; acc_active = 0; delay = 0;
        obs_if_done = 0; obs_mem_done = 0;
        model_reset();

        @(negedge clk);
        check_eq("rst_portReq", portReq, 0);
        check_eq("rst_portWe", portWe, 0);
        check_eq("rst_portAddr", portAddr, 0);
        check_eq("rst_portWdata", portWdata, 0);
        check_eq("rst_ifRdata", ifRdata, 0);
        check_eq("rst_memRdata", memRdata, 0);
        check_eq("rst_ifDone", ifDone, 0);
        check_eq("rst_memDone", memDone, 0);
        check_eq("rst_arbError", arbError, 0);
        @(posedge clk);
        #1;
        resetManual = 1;

        repeat (3000) step();

        // Unresponsive memory: waits forever, or times out when enabled.
        hold_ready = 1;
        repeat (40) step();
        hold_ready = 0;
        repeat (20) step();

        // Asynchronous reset in the middle of a store (read+write both high).
        rand_en = 0;
        ifReq = 0; memRead = 0; memWrite = 0;
        resetManual = 0;
        model_reset();
        hold_ready = 1;
        step();
        resetManual = 1;
        memRead = 1; memWrite = 1; memAddr = 32'h20; memWdata = 32'hDEAD_BEEF;
        step();
        step();
        step();
        #2;
        resetManual = 0;
        #1;
        check_eq("arst_portReq", portReq, 0);
        check_eq("arst_memDone", memDone, 0);
        check_eq("arst_portWe", portWe, 0);
        check_eq("arst_portAddr", portAddr, 0);
        model_reset();
        memRead = 0; memWrite = 0;
        @(posedge clk);
        #1;
        resetManual = 1;
        hold_ready = 0;
        repeat (3) step();

        rand_en = 1;
        repeat (500) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
